// File: rtl/ah_snoop_fifo_param_if.sv
// Bus bundle for the snoopable FIFO: write, read and snoop ports.
// The master is the producer/consumer side; the slave is the FIFO.
interface ah_snoop_fifo_param_if #(
  parameter int DATA_W = 132,
  parameter int DEPTH  = 20,
  parameter int KEY_W  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;
  logic [KEY_W-1:0]  sdata;
  logic              svalid;
  logic              smatch;
  logic [CNT_W-1:0]  smatch_cnt;
  logic [CNT_W-1:0]  count;

  modport master (
    output wdata, wvalid, rready,
    output sdata, svalid,
    input  wready, rdata, rvalid,
    input  smatch, smatch_cnt, count
  );

  modport slave (
    input  wdata, wvalid, rready,
    input  sdata, svalid,
    output wready, rdata, rvalid,
    output smatch, smatch_cnt, count
  );
endinterface

// File: rtl/ah_snoop_fifo_param.sv
// Parametrised valid/ready FIFO with a content-addressable snoop port.
// Snoop reports hit/popcount over occupied entries, one cycle later.
module ah_snoop_fifo_param #(
  parameter int DATA_W  = 132,
  parameter int DEPTH   = 20,
  parameter int KEY_W   = 16,
  parameter int KEY_LSB = 0
) (
  input logic                 clk,
  input logic                 rstn,
  ah_snoop_fifo_param_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  occ;
  logic [DEPTH-1:0]  occ_nxt;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  cnt;
  logic              wr_fire;
  logic              rd_fire;
  logic [DEPTH-1:0]  hit;
  logic [CNT_W-1:0]  hit_cnt;

  function automatic logic [IDX_W-1:0] adv(
    input logic [IDX_W-1:0] i
  );
    return (i == LAST) ? '0 : i + IDX_W'(1);
  endfunction

  assign bus.wready = (cnt != FULL);
  assign bus.rvalid = (cnt != '0);
  assign bus.rdata  = bus.rvalid ? mem[rd_idx] : '0;
  assign bus.count  = cnt;

  assign wr_fire = bus.wvalid && bus.wready;
  assign rd_fire = bus.rready && bus.rvalid;

  // Compare uses pre-edge state: same-cycle writes are not yet occupied.
  always_comb begin
    hit     = '0;
    hit_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i]  = occ[i] &&
                (mem[i][KEY_LSB +: KEY_W] == bus.sdata);
      hit_cnt = hit_cnt + CNT_W'(hit[i]);
    end
  end

  always_comb begin
    occ_nxt = occ;
    if (rd_fire) occ_nxt[rd_idx] = 1'b0;
    if (wr_fire) occ_nxt[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_idx] <= bus.wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_idx         <= '0;
      rd_idx         <= '0;
      cnt            <= '0;
      occ            <= '0;
      bus.smatch     <= 1'b0;
      bus.smatch_cnt <= '0;
    end else begin
      if (wr_fire) wr_idx <= adv(wr_idx);
      if (rd_fire) rd_idx <= adv(rd_idx);
      occ <= occ_nxt;
      unique case (1'b1)
        wr_fire && !rd_fire: cnt <= cnt + CNT_W'(1);
        rd_fire && !wr_fire: cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
      if (bus.svalid) begin
        bus.smatch     <= |hit;
        bus.smatch_cnt <= hit_cnt;
      end
    end
  end
endmodule
